// File: rtl/matmul_arbiter.sv
// Round-robin scheduler sharing one 2x2 8-bit matrix-multiply engine among NUM_REQ requesters.
// Optional engine watchdog compiled in with MATMUL_ARB_TIMEOUT_EN.
module matmul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 31
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [32*NUM_REQ-1:0]  req_b,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     done,
  output logic [NUM_REQ-1:0]     err,
  output logic [31:0]            res,
  output logic                   eng_start,
  output logic [31:0]            eng_a,
  output logic [31:0]            eng_b,
  input  logic                   eng_done,
  input  logic [31:0]            eng_res,
  output logic                   eng_rst
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t               state, state_n;
  logic [PW-1:0]        ptr, ptr_n, cur, cur_n, sel, ptr_adv;
  logic [PW:0]          idx;
  logic                 hit;
  logic [NUM_REQ-1:0]   gnt_n, done_n;
  logic [31:0]          res_n, a_n, b_n;
  logic                 start_n, eng_rst_n;

`ifdef MATMUL_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]        cnt, cnt_n;
  logic [NUM_REQ-1:0]   err_n;
`else
  assign err = '0;
`endif

  // First set request at or after ptr, wrapping; idx never exceeds 2*NUM_REQ-2.
  always_comb begin
    hit = 1'b0;
    sel = ptr;
    idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr} + (PW+1)'(k);
      if (idx >= (PW+1)'(NUM_REQ))
        idx = idx - (PW+1)'(NUM_REQ);
      if (!hit && req[idx[PW-1:0]]) begin
        hit = 1'b1;
        sel = idx[PW-1:0];
      end
    end
  end

  assign ptr_adv = (cur == PW'(NUM_REQ - 1)) ? '0 : PW'(cur + 1'b1);

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    cur_n     = cur;
    gnt_n     = gnt;
    done_n    = '0;
    res_n     = res;
    start_n   = 1'b0;
    a_n       = eng_a;
    b_n       = eng_b;
    eng_rst_n = 1'b1;
`ifdef MATMUL_ARB_TIMEOUT_EN
    err_n     = '0;
    cnt_n     = cnt;
`endif
    unique case (state)
      IDLE: begin
        if (hit) begin
          gnt_n      = '0;
          gnt_n[sel] = 1'b1;
          cur_n      = sel;
          a_n        = req_a[32*sel +: 32];
          b_n        = req_b[32*sel +: 32];
          start_n    = 1'b1;
          state_n    = WAIT;
`ifdef MATMUL_ARB_TIMEOUT_EN
          cnt_n      = '0;
`endif
        end
      end
      WAIT: begin
        if (eng_done) begin
          res_n   = eng_res;
          done_n  = gnt;
          gnt_n   = '0;
          ptr_n   = ptr_adv;
          state_n = RESP;
        end
`ifdef MATMUL_ARB_TIMEOUT_EN
        // cnt holds the number of WAIT edges seen; this edge makes it TIMEOUT.
        else if (cnt == CW'(TIMEOUT - 1)) begin
          err_n     = gnt;
          gnt_n     = '0;
          eng_rst_n = 1'b0;
          ptr_n     = ptr_adv;
          state_n   = RESP;
        end else begin
          cnt_n = CW'(cnt + 1'b1);
        end
`endif
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      ptr       <= '0;
      cur       <= '0;
      gnt       <= '0;
      done      <= '0;
      res       <= '0;
      eng_start <= 1'b0;
      eng_a     <= '0;
      eng_b     <= '0;
      eng_rst   <= 1'b0;
`ifdef MATMUL_ARB_TIMEOUT_EN
      err       <= '0;
      cnt       <= '0;
`endif
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      cur       <= cur_n;
      gnt       <= gnt_n;
      done      <= done_n;
      res       <= res_n;
      eng_start <= start_n;
      eng_a     <= a_n;
      eng_b     <= b_n;
      eng_rst   <= eng_rst_n;
`ifdef MATMUL_ARB_TIMEOUT_EN
      err       <= err_n;
      cnt       <= cnt_n;
`endif
    end
  end

endmodule

// File: tb/tb_matmul_arbiter.sv
// Directed self-checking bench for matmul_arbiter; timeout cases run when MATMUL_ARB_TIMEOUT_EN is defined.
module tb_matmul_arbiter;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [32*N-1:0] req_a, req_b;
  logic [N-1:0]    gnt, done, err;
  logic [31:0]     res;
  logic            eng_start;
  logic [31:0]     eng_a, eng_b;
  logic            eng_done;
  logic [31:0]     eng_res;
  logic            eng_rst;

  int vectors = 0;
  int fails   = 0;

  matmul_arbiter #(.NUM_REQ(N), .TIMEOUT(31)) dut (
    .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .done(done), .err(err), .res(res),
    .eng_start(eng_start), .eng_a(eng_a), .eng_b(eng_b),
    .eng_done(eng_done), .eng_res(eng_res), .eng_rst(eng_rst)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Engine model: 2x2 multiply of 8-bit elements, each result element mod 256.
  function automatic logic [31:0] mm(input logic [31:0] a, input logic [31:0] b);
    logic [7:0] a00, a01, a10, a11, b00, b01, b10, b11;
    {a00, a01, a10, a11} = a;
    {b00, b01, b10, b11} = b;
    return {8'(a00*b00 + a01*b10), 8'(a00*b01 + a01*b11),
            8'(a10*b00 + a11*b10), 8'(a10*b01 + a11*b11)};
  endfunction

  // Returns at the sample point just after the edge that captured eng_done.
  task automatic engine(input int lat);
    repeat (lat) tick();
    eng_done = 1'b1;
    eng_res  = mm(eng_a, eng_b);
    tick();
    eng_done = 1'b0;
  endtask

  logic [31:0] a_tab [N] = '{32'h01000001, 32'h02000002, 32'h03000003, 32'h04000004};
  logic [31:0] r_tab [N] = '{32'h01020304, 32'h02040608, 32'h0306090C, 32'h04080C10};
  int          ord   [5] = '{0, 1, 2, 3, 0};

  initial begin
    rst = 1'b0; req = '0; req_a = '0; req_b = '0; eng_done = 1'b0; eng_res = '0;
    repeat (2) tick();
    check("rst_gnt",   32'(gnt), 32'h0);
    check("rst_done",  32'(done), 32'h0);
    check("rst_err",   32'(err), 32'h0);
    check("rst_res",   res, 32'h0);
    check("rst_start", 32'(eng_start), 32'h0);
    check("rst_eng_a", eng_a, 32'h0);
    check("rst_eng_b", eng_b, 32'h0);
    check("rst_eng_rst", 32'(eng_rst), 32'h0);
    rst = 1'b1;
    tick();
    check("eng_rst_rise", 32'(eng_rst), 32'h1);
    check("idle_gnt", 32'(gnt), 32'h0);

    // Single request
    req_a[31:0] = 32'h01020304;
    req_b[31:0] = 32'h05060708;
    req = 4'b0001;
    tick();
    check("t1_gnt",   32'(gnt), 32'h1);
    check("t1_start", 32'(eng_start), 32'h1);
    check("t1_eng_a", eng_a, 32'h01020304);
    check("t1_eng_b", eng_b, 32'h05060708);
    tick();
    check("t1_start_fall", 32'(eng_start), 32'h0);
    check("t1_gnt_hold",   32'(gnt), 32'h1);
    engine(8);
    check("t1_done", 32'(done), 32'h1);
    check("t1_res",  res, 32'h13162B32);
    check("t1_gnt_clr", 32'(gnt), 32'h0);
    req = '0;
    tick();
    check("t1_done_fall", 32'(done), 32'h0);
    tick();
    check("t1_idle_gnt", 32'(gnt), 32'h0);
    eng_done = 1'b1; eng_res = 32'hDEADBEEF;
    tick();
    eng_done = 1'b0;
    check("stray_done", 32'(done), 32'h0);
    check("stray_res",  res, 32'h13162B32);

    // All requesters high continuously, starting from ptr = 0
    rst = 1'b0; tick(); rst = 1'b1; tick();
    req_a = {a_tab[3], a_tab[2], a_tab[1], a_tab[0]};
    req_b = {4{32'h01020304}};
    req   = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      tick();
      check($sformatf("rr%0d_gnt", j),   32'(gnt), 32'(1) << ord[j]);
      check($sformatf("rr%0d_eng_a", j), eng_a, a_tab[ord[j]]);
      engine(3);
      check($sformatf("rr%0d_done", j), 32'(done), 32'(1) << ord[j]);
      check($sformatf("rr%0d_res", j),  res, r_tab[ord[j]]);
      if (j == 4) req = '0;
      tick();
      check($sformatf("rr%0d_resp_gnt", j), 32'(gnt), 32'h0);
    end

    // Serve 2, then 0101 wraps from ptr 3 to requester 0
    req = 4'b0100;
    tick();
    check("wrap_gnt2", 32'(gnt), 32'h4);
    engine(2);
    check("wrap_done2", 32'(done), 32'h4);
    check("wrap_res2",  res, 32'h0306090C);
    req = 4'b0101;
    tick();
    check("wrap_resp_gnt", 32'(gnt), 32'h0);
    tick();
    check("wrap_gnt0", 32'(gnt), 32'h1);
    req = '0;
    engine(4);
    check("drop_done0", 32'(done), 32'h1);
    check("drop_res0",  res, 32'h01020304);
    tick();

    // Persistent requester 1 served back-to-back; operands held while busy
    req = 4'b0010;
    tick();
    check("bb1_gnt",   32'(gnt), 32'h2);
    check("bb1_eng_a", eng_a, 32'h02000002);
    req_a[63:32] = 32'hFFFFFFFF;
    req_b[63:32] = 32'hFFFFFFFF;
    tick();
    check("bb1_a_stable", eng_a, 32'h02000002);
    check("bb1_b_stable", eng_b, 32'h01020304);
    engine(2);
    check("bb1_done", 32'(done), 32'h2);
    check("bb1_res",  res, 32'h02040608);
    tick();
    tick();
    check("bb2_gnt",   32'(gnt), 32'h2);
    check("bb2_eng_a", eng_a, 32'hFFFFFFFF);
    engine(1);
    check("bb2_done", 32'(done), 32'h2);
    check("bb2_res_wrap", res, 32'h02020202);
    req = '0;
    tick();

    // Reset during WAIT for requester 1
    req = 4'b0010;
    tick();
    check("mr_gnt", 32'(gnt), 32'h2);
    tick();
    rst = 1'b0; eng_done = 1'b1; eng_res = 32'h12345678;
    tick();
    check("mr_gnt0",    32'(gnt), 32'h0);
    check("mr_done0",   32'(done), 32'h0);
    check("mr_start0",  32'(eng_start), 32'h0);
    check("mr_eng_a0",  eng_a, 32'h0);
    check("mr_eng_b0",  eng_b, 32'h0);
    check("mr_res0",    res, 32'h0);
    check("mr_eng_rst", 32'(eng_rst), 32'h0);
    eng_done = 1'b0;
    tick();
    check("mr_eng_rst_hold", 32'(eng_rst), 32'h0);
    check("mr_done_hold",    32'(done), 32'h0);
    rst = 1'b1;
    tick();
    check("mr_regnt",   32'(gnt), 32'h2);
    check("mr_eng_rst_rise", 32'(eng_rst), 32'h1);
    engine(2);
    check("mr_done", 32'(done), 32'h2);
    check("mr_res",  res, 32'h02020202);
    req = '0;
    tick();

`ifdef MATMUL_ARB_TIMEOUT_EN
    // Engine never responds: watchdog fires 31 cycles after eng_start
    req = 4'b0001;
    tick();
    check("to_gnt", 32'(gnt), 32'h1);
    req = '0;
    repeat (30) tick();
    check("to_err_early", 32'(err), 32'h0);
    check("to_gnt_early", 32'(gnt), 32'h1);
    tick();
    check("to_err",     32'(err), 32'h1);
    check("to_done",    32'(done), 32'h0);
    check("to_eng_rst", 32'(eng_rst), 32'h0);
    check("to_gnt_clr", 32'(gnt), 32'h0);
    check("to_res",     res, 32'h02020202);
    tick();
    check("to_err_fall",     32'(err), 32'h0);
    check("to_eng_rst_rise", 32'(eng_rst), 32'h1);
    // Completion on the watchdog cycle: done wins
    req = 4'b0001;
    tick();
    check("tie_gnt", 32'(gnt), 32'h1);
    req = '0;
    repeat (30) tick();
    eng_done = 1'b1; eng_res = mm(eng_a, eng_b);
    tick();
    eng_done = 1'b0;
    check("tie_done",    32'(done), 32'h1);
    check("tie_err",     32'(err), 32'h0);
    check("tie_res",     res, 32'h01020304);
    check("tie_eng_rst", 32'(eng_rst), 32'h1);
    tick();
`else
    check("err_tied", 32'(err), 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
